// File: rtl/resp_capture_pkg.sv
// Shared definitions for the response-capture block: FSM states, MISR polynomial
// and the record layout pushed into the record FIFO.
package resp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [15:0] POLY = 16'h1021;

    // Record layout at the default pattern width; rec_data is this packed struct.
    localparam int REC_PAT_W = 5;

    typedef struct packed {
        logic [REC_PAT_W-1:0] pattern;
        logic                 resp;
    } rec_t;

endpackage

// File: rtl/resp_fifo.sv
// Small first-word-fall-through FIFO for capture records; push while full is
// accepted only when a pop happens in the same cycle.
module resp_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Head is shown combinationally so a record is visible the cycle after its push.
    assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/resp_capture.sv
// Sweeps 2^PAT_W stimulus samples: checks pattern order, counts response
// mismatches, compacts responses into a MISR and forwards {pattern, resp} records.
module resp_capture
    import resp_capture_pkg::*;
#(
    parameter int PAT_W  = 5,
    parameter int DEPTH  = 4,
    parameter int MISR_W = 16
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              smp_valid,
    input  logic [PAT_W-1:0]  smp_pattern,
    input  logic              smp_resp,
    input  logic              smp_golden,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [PAT_W:0]    rec_data,
    output logic [PAT_W:0]    mismatch_cnt,
    output logic [MISR_W-1:0] signature,
    output logic              overflow,
    output logic              seq_err,
    output logic              done
);

    localparam logic [MISR_W-1:0] POLY_W   = MISR_W'(POLY);
    localparam logic [PAT_W:0]    CNT_MAX  = {1'b1, {PAT_W{1'b0}}};
    localparam logic [PAT_W-1:0]  IDX_LAST = {PAT_W{1'b1}};

    state_e              state_reg;
    logic [PAT_W-1:0]    idx_reg;
    logic [PAT_W:0]      mismatch_cnt_reg;
    logic [MISR_W-1:0]   sig_reg;
    logic [MISR_W-1:0]   sig_next;
    logic                overflow_reg;
    logic                seq_err_reg;
    logic                done_reg;
    logic                sample_fire;
    logic                rec_pop;
    logic                fifo_full;
    logic                fifo_empty;

    assign sample_fire = (state_reg == ST_CAPTURE) && smp_valid;
    assign rec_valid   = !fifo_empty;
    assign rec_pop     = rec_valid && rec_ready;

    assign sig_next = {sig_reg[MISR_W-2:0], 1'b0}
                    ^ (sig_reg[MISR_W-1] ? POLY_W : '0)
                    ^ {{(MISR_W-1){1'b0}}, smp_resp};

    resp_fifo #(
        .W     (PAT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CK),
        .rst_n (reset),
        .push  (sample_fire),
        .pop   (rec_pop),
        .din   ({smp_pattern, smp_resp}),
        .dout  (rec_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            mismatch_cnt_reg <= '0;
            sig_reg          <= '0;
            overflow_reg     <= 1'b0;
            seq_err_reg      <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg        <= ST_CAPTURE;
                        idx_reg          <= '0;
                        mismatch_cnt_reg <= '0;
                        sig_reg          <= '1;
                        overflow_reg     <= 1'b0;
                        seq_err_reg      <= 1'b0;
                        done_reg         <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (smp_valid) begin
                        if (smp_pattern != idx_reg) seq_err_reg <= 1'b1;
                        if ((smp_resp != smp_golden) && (mismatch_cnt_reg != CNT_MAX))
                            mismatch_cnt_reg <= mismatch_cnt_reg + 1'b1;
                        // Full FIFO drops the record unless the head leaves this cycle.
                        if (fifo_full && !rec_pop) overflow_reg <= 1'b1;
                        sig_reg <= sig_next;
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_reg == IDX_LAST) state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mismatch_cnt = mismatch_cnt_reg;
    assign signature    = sig_reg;
    assign overflow     = overflow_reg;
    assign seq_err      = seq_err_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_resp_capture.sv
// Directed bench for resp_capture: sweeps with hand-chosen response/pattern
// disturbances, back-pressure, FIFO full corner and asynchronous reset.
module tb_resp_capture;
    import resp_capture_pkg::*;

    localparam int PAT_W  = 5;
    localparam int DEPTH  = 4;
    localparam int MISR_W = 16;
    localparam int N      = 32;

    logic              CK = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              smp_valid = 1'b0;
    logic [PAT_W-1:0]  smp_pattern = '0;
    logic              smp_resp = 1'b0;
    logic              smp_golden = 1'b0;
    logic              rec_ready = 1'b0;
    logic              rec_valid;
    logic [PAT_W:0]    rec_data;
    logic [PAT_W:0]    mismatch_cnt;
    logic [MISR_W-1:0] signature;
    logic              overflow;
    logic              seq_err;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [PAT_W:0]  got[$];
    logic [PAT_W:0]  exp_q[$];
    logic [15:0]     exp_sig;
    logic [31:0]     seq_hist;
    bit              timed_out;

    resp_capture #(.PAT_W(PAT_W), .DEPTH(DEPTH), .MISR_W(MISR_W)) dut (
        .CK           (CK),
        .reset        (reset),
        .start        (start),
        .smp_valid    (smp_valid),
        .smp_pattern  (smp_pattern),
        .smp_resp     (smp_resp),
        .smp_golden   (smp_golden),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_data     (rec_data),
        .mismatch_cnt (mismatch_cnt),
        .signature    (signature),
        .overflow     (overflow),
        .seq_err      (seq_err),
        .done         (done)
    );

    always #5 CK = ~CK;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    function automatic logic golden_of(input logic [PAT_W-1:0] p);
        return p[0] ^ p[3];
    endfunction

    // One clock: note a record leaving at this edge, then settle 1 ns past the edge.
    task automatic tick();
        if (rec_valid && rec_ready) got.push_back(rec_data);
        @(posedge CK);
        #1;
    endtask

    task automatic set_sample(input int k, input logic inv, input bit swap12);
        logic [PAT_W-1:0] p;
        p = PAT_W'(k);
        if (swap12 && k == 1) p = 5'd2;
        if (swap12 && k == 2) p = 5'd1;
        smp_valid   = 1'b1;
        smp_pattern = p;
        smp_golden  = golden_of(p);
        smp_resp    = golden_of(p) ^ inv;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30 && done !== 1'b1; n++) tick();
        timed_out = (done !== 1'b1);
    endtask

    task automatic do_sweep(input logic [31:0] inv_mask, input bit swap12);
        got.delete();
        exp_q.delete();
        exp_sig  = 16'hFFFF;
        seq_hist = '0;
        rec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_sample(k, inv_mask[k], swap12);
            exp_q.push_back({smp_pattern, smp_resp});
            exp_sig = misr_step(exp_sig, smp_resp);
            tick();
            seq_hist[k] = seq_err;
        end
        smp_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rec_valid, rec_data, mismatch_cnt, overflow, seq_err, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {rec_valid, rec_data, mismatch_cnt, overflow, seq_err, done});
        end
        checks++;
        if (signature !== 16'h0000) begin
            errors++;
            $display("FAIL reset_signature: got %h, expected 0000", signature);
        end
        reset = 1'b1;
        rec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_sample(k, 1'b1, 1'b0);
            tick();
        end
        smp_valid = 1'b0;
        checks++;
        if (rec_valid !== 1'b0 || mismatch_cnt !== '0 || signature !== 16'h0000) begin
            errors++;
            $display("FAIL idle_ignores_samples: rec_valid=%b mismatch=%0d sig=%h, expected 0/0/0000",
                     rec_valid, mismatch_cnt, signature);
        end
    endtask

    task automatic test_clean_sweep(input string tag);
        do_sweep(32'h0, 1'b0);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b, expected 1 within bound", tag, done);
        end
        checks++;
        if (got.size() !== N) begin
            errors++;
            $display("FAIL %s_record_count: got %0d, expected %0d", tag, got.size(), N);
        end
        for (int i = 0; i < got.size() && i < N; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_record[%0d]: got %b, expected %b", tag, i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (mismatch_cnt !== 6'd0 || seq_err !== 1'b0 || overflow !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_status: mismatch=%0d seq_err=%b overflow=%b done=%b, expected 0/0/0/1",
                     tag, mismatch_cnt, seq_err, overflow, done);
        end
        checks++;
        if (signature !== exp_sig) begin
            errors++;
            $display("FAIL %s_signature: got %h, expected %h", tag, signature, exp_sig);
        end
    endtask

    task automatic test_single_mismatch();
        int   bad;
        rec_t r;
        do_sweep(32'h0000_0020, 1'b0);
        checks++;
        if (timed_out || mismatch_cnt !== 6'd1) begin
            errors++;
            $display("FAIL single_mismatch_cnt: got %0d (timeout=%0d), expected 1", mismatch_cnt, timed_out);
        end
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            r = got[i];
            if (r.resp !== golden_of(r.pattern)) begin
                bad++;
                checks++;
                if (r.pattern !== 5'd5) begin
                    errors++;
                    $display("FAIL single_mismatch_where: pattern %b differs, expected only 00101", r.pattern);
                end
            end
        end
        checks++;
        if (bad !== 1 || got.size() !== N) begin
            errors++;
            $display("FAIL single_mismatch_records: %0d differing of %0d, expected 1 of %0d", bad, got.size(), N);
        end
        checks++;
        if (signature !== exp_sig) begin
            errors++;
            $display("FAIL single_mismatch_signature: got %h, expected %h", signature, exp_sig);
        end
    endtask

    task automatic test_all_mismatch();
        do_sweep(32'hFFFF_FFFF, 1'b0);
        checks++;
        if (timed_out || mismatch_cnt !== 6'd32) begin
            errors++;
            $display("FAIL all_mismatch_cnt: got %0d (timeout=%0d), expected 32", mismatch_cnt, timed_out);
        end
        checks++;
        if (signature !== exp_sig) begin
            errors++;
            $display("FAIL all_mismatch_signature: got %h, expected %h", signature, exp_sig);
        end
    endtask

    task automatic test_seq_err();
        do_sweep(32'h0, 1'b1);
        checks++;
        if (seq_hist[0] !== 1'b0 || seq_hist[1] !== 1'b1 || seq_hist[31] !== 1'b1) begin
            errors++;
            $display("FAIL seq_err_timing: after s0/s1/s31 got %b%b%b, expected 011",
                     seq_hist[0], seq_hist[1], seq_hist[31]);
        end
        checks++;
        if (timed_out || done !== 1'b1 || got.size() !== N) begin
            errors++;
            $display("FAIL seq_err_completion: done=%b records=%0d, expected 1/%0d", done, got.size(), N);
        end
        checks++;
        if (got.size() > 1 && got[1] !== {5'd2, golden_of(5'd2)}) begin
            errors++;
            $display("FAIL seq_err_record1: got %b, expected %b", got[1], {5'd2, golden_of(5'd2)});
        end
    endtask

    task automatic test_backpressure();
        rec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_sample(k, 1'b0, 1'b0);
            tick();
            if (k == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_no_overflow_at_4: got %b, expected 0", overflow);
                end
            end
            if (k == 4) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_overflow_at_5: got %b, expected 1", overflow);
                end
            end
        end
        smp_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (done !== 1'b0 || rec_valid !== 1'b1 || rec_data !== {5'd0, golden_of(5'd0)}) begin
            errors++;
            $display("FAIL bp_drain_hold: done=%b rec_valid=%b data=%b, expected 0/1/%b",
                     done, rec_valid, rec_data, {5'd0, golden_of(5'd0)});
        end
        got.delete();
        rec_ready = 1'b1;
        wait_done();
        checks++;
        if (timed_out || got.size() !== DEPTH) begin
            errors++;
            $display("FAIL bp_pop_count: got %0d pops (timeout=%0d), expected %0d", got.size(), timed_out, DEPTH);
        end
        for (int j = 0; j < got.size() && j < DEPTH; j++) begin
            checks++;
            if (got[j] !== {PAT_W'(j), golden_of(PAT_W'(j))}) begin
                errors++;
                $display("FAIL bp_record[%0d]: got %b, expected %b", j, got[j], {PAT_W'(j), golden_of(PAT_W'(j))});
            end
        end
    endtask

    task automatic test_full_push_pop();
        rec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_sample(k, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (overflow !== 1'b0 || rec_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: overflow=%b rec_valid=%b, expected 0/1", overflow, rec_valid);
        end
        rec_ready = 1'b1;
        set_sample(4, 1'b0, 1'b0);
        tick();
        checks++;
        if (overflow !== 1'b0 || rec_data !== {5'd1, golden_of(5'd1)}) begin
            errors++;
            $display("FAIL full_push_pop: overflow=%b head=%b, expected 0/%b",
                     overflow, rec_data, {5'd1, golden_of(5'd1)});
        end
        rec_ready = 1'b0;
        set_sample(5, 1'b0, 1'b0);
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_still_full: overflow=%b, expected 1", overflow);
        end
        rec_ready = 1'b1;
        for (int k = 6; k < N; k++) begin
            set_sample(k, 1'b0, 1'b0);
            start = (k == 6);
            tick();
        end
        start = 1'b0;
        smp_valid = 1'b0;
        wait_done();
        checks++;
        if (timed_out || seq_err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_in_capture: seq_err=%b done=%b, expected 0/1", seq_err, done);
        end
    endtask

    task automatic test_reset_mid();
        rec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_sample(k, k[0], 1'b0);
            tick();
        end
        smp_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({rec_valid, rec_data, mismatch_cnt, signature, overflow, seq_err, done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected all zero",
                     {rec_valid, rec_data, mismatch_cnt, signature, overflow, seq_err, done});
        end
        @(posedge CK);
        #1;
        checks++;
        if ({rec_valid, mismatch_cnt, signature, done} !== '0) begin
            errors++;
            $display("FAIL reset_held: got %b, expected all zero", {rec_valid, mismatch_cnt, signature, done});
        end
        reset = 1'b1;
        test_clean_sweep("restart");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_sweep("clean");
        test_single_mismatch();
        test_all_mismatch();
        test_seq_err();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
